lane_snapshot_serializer: RTL and testbench
===========================================

// Module: lane_snapshot_serializer
// PURPOSE
//  Downstream consumer of the generated four-lane top (lanes a,b,c,d, 8 bit each).
//  Watches all four lanes every cycle and captures a snapshot whenever any lane changes.
//  Snapshots are buffered in a small FIFO and serialized one byte per beat (a,b,c,d order)
//  over a valid/ready stream, so a bench or logger can record the lane evolution without
//  per-cycle polling.
// PARAMETERS
//  DATA_W  8  lane width; also the width of out_data
//  DEPTH   4  snapshot FIFO entries; must be a power of 2 and >= 2
//  CNT_W   8  width of the saturating drop counter
// PORTS
//  clk         in   1              single clock, rising edge
//  rst         in   1              asynchronous, active-low reset (0 = reset)
//  en          in   1              sampling enable; lanes are ignored while 0
//  a,b,c,d     in   DATA_W each    lane values from the upstream top
//  out_data    out  DATA_W         current serialized byte
//  out_lane    out  2              lane index of out_data (0=a,1=b,2=c,3=d)
//  out_last    out  1              1 on the lane-d beat of a snapshot
//  out_valid   out  1              beat valid
//  out_ready   in   1              consumer accepts the beat when valid&ready
//  fifo_level  out  $clog2(DEPTH)+1  entries held, including the entry being sent
//  drop_cnt    out  CNT_W          snapshots lost to a full FIFO; saturates at all-ones
//  overflow    out  1              sticky; set on the first drop
// BEHAVIOUR
//  - Reset (rst=0, async): every register clears. Outputs out_valid=0, out_data=0,
//    out_lane=0, out_last=0, fifo_level=0, drop_cnt=0, overflow=0. The FSM goes to IDLE.
//    The prev-lane registers clear to 0 and the first flag sets to 1.
//    Reset mid-burst discards the partially sent snapshot; no resume.
//  - Capture (en=1): capture condition = first | ({a,b,c,d} != prev).
//    When en=1, prev <= {a,b,c,d} and first <= 0, whether or not the push succeeds.
//    When en=0, prev and first hold.
//  - Push: a capture writes {a,b,c,d} into the FIFO at the clock edge.
//    If the FIFO is full and no slot frees in the same cycle:
//    the snapshot is dropped, drop_cnt increments (saturating), and overflow <= 1.
//  - Pop/serializer FSM
//    - IDLE: when the FIFO is non-empty, load the head entry and go to SEND with idx=0.
//    - SEND: out_valid=1, out_data=lane[idx], out_lane=idx, out_last=(idx==3).
//    - On valid&ready: idx increments. On the idx==3 handshake the head entry is popped.
//      If another entry is waiting, the FSM goes straight to SEND idx=0 of the next entry
//      (no bubble); otherwise it goes to IDLE.
//    - While out_valid=1 and out_ready=0, out_data, out_lane and out_last hold stable.
//  - Latency: lanes change at edge N (sampled in cycle N). First beat valid in cycle N+1
//    if the FIFO was empty. A snapshot takes 4 beats at full throughput.
//  - Simultaneous push and final pop while full: the push is accepted; no drop.
//  - fifo_level counts the entry being serialized until its last beat is accepted.
//  - Pointers wrap modulo DEPTH. Full/empty is distinguished by an extra pointer bit.
// STRUCTURE
//  - Shared package lane_snap_pkg:
//    - typedef snapshot_t = 4 x DATA_W packed {a,b,c,d}
//    - state enum {IDLE, SEND}
//    - localparam LANES = 4
//  - One sub-module, snap_fifo: DEPTH x 4*DATA_W, push/pop/full/empty/level.
//  - The top level holds the capture logic, drop counter and serializer FSM.
// TESTING
//  1. Reset 1 cycle, then en=1 with a..d = 8,7,6,5 held and out_ready=1
//     -> exactly 4 beats 8,7,6,5 with lanes 0..3 and out_last only on 5;
//     then no further beats.
//  2. Hold the lanes at 9,8,7,6 for 10 cycles after the 8,7,6,5 snapshot
//     -> exactly one extra snapshot (9,8,7,6). fifo_level returns to 0.
//  3. out_ready=0 while 6 distinct lane values arrive (DEPTH=4)
//     -> fifo_level=4, drop_cnt=2, overflow=1.
//     Then release ready -> 16 beats in arrival order.
//  4. Toggle out_ready every cycle during a snapshot
//     -> out_data is stable across stalls; every byte is delivered once, in order.
//  5. Assert rst=0 mid-burst, after beat 2 -> out_valid=0 immediately (async).
//     After release, the first en=1 cycle re-captures the current lanes even if unchanged.
//  6. en=0 while the lanes change, then en=1 with the lanes equal to the last captured
//     value -> no snapshot.
//     Drive drop_cnt past 255 -> it holds at 255.

Source files
------------

// File: rtl/lane_snap_pkg.sv
// Shared types for the lane snapshot serializer: lane count, snapshot layout
// and serializer states.
package lane_snap_pkg;
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 8;

    // Packed {a,b,c,d}; lane a occupies the most significant byte.
    typedef logic [LANES-1:0][LANE_W-1:0] snapshot_t;

    typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/lane_snapshot_serializer_fifo.sv
// Snapshot FIFO with head and head+1 peek ports so the serializer can chain
// snapshots without a bubble. Pointers carry an extra wrap bit for full/empty.
module snap_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head,
    output logic [W-1:0]             next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW-1:0] nidx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    assign nidx  = rptr[AW-1:0] + 1'b1;
    assign head  = mem[rptr[AW-1:0]];
    assign next  = mem[nidx];
    assign level = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

// File: rtl/lane_snapshot_serializer.sv
// Captures {a,b,c,d} whenever any lane changes, buffers snapshots and streams
// them one lane per beat over valid/ready, counting snapshots lost to a full FIFO.
module lane_snapshot_serializer
    import lane_snap_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DATA_W-1:0]        a,
    input  logic [DATA_W-1:0]        b,
    input  logic [DATA_W-1:0]        c,
    input  logic [DATA_W-1:0]        d,
    output logic [DATA_W-1:0]        out_data,
    output logic [1:0]               out_lane,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     overflow
);
    localparam int unsigned SW    = LANES * DATA_W;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    function automatic logic [DATA_W-1:0] lane_of(input logic [SW-1:0] s, input logic [1:0] i);
        return s[(LANES - 1 - int'(i)) * DATA_W +: DATA_W];
    endfunction

    state_t          state;
    logic [SW-1:0]   cur, prev, snap, head, next, load_val;
    logic            first, capture, push, drop, last_pop, full, empty, load;
    logic [1:0]      nxt_idx;

    assign cur      = {a, b, c, d};
    assign capture  = en && (first || (cur != prev));
    assign last_pop = out_valid && out_ready && out_last;
    // A slot freed by the final beat in the same cycle makes room for the capture.
    assign push     = capture && (!full || last_pop);
    assign drop     = capture && full && !last_pop;
    assign nxt_idx  = out_lane + 2'd1;

    snap_fifo #(.W(SW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (last_pop),
        .wdata (cur),
        .head  (head),
        .next  (next),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Pick the snapshot to start sending; live lanes bypass the FIFO read when
    // the captured entry will be the new head.
    always_comb begin
        load     = 1'b0;
        load_val = head;
        if (state == IDLE) begin
            if (!empty) begin
                load = 1'b1;
            end else if (push) begin
                load     = 1'b1;
                load_val = cur;
            end
        end else if (last_pop) begin
            if (fifo_level > LVL_W'(1)) begin
                load     = 1'b1;
                load_val = next;
            end else if (push) begin
                load     = 1'b1;
                load_val = cur;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            snap      <= '0;
            out_data  <= '0;
            out_lane  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            state     <= SEND;
            snap      <= load_val;
            out_data  <= lane_of(load_val, 2'd0);
            out_lane  <= 2'd0;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
        end else if (state == SEND && out_valid && out_ready) begin
            if (out_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_lane  <= 2'd0;
                out_last  <= 1'b0;
            end else begin
                out_data <= lane_of(snap, nxt_idx);
                out_lane <= nxt_idx;
                out_last <= (nxt_idx == 2'd3);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev     <= '0;
            first    <= 1'b1;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (en) begin
                prev  <= cur;
                first <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lane_snapshot_serializer.sv
// Scenario bench for lane_snapshot_serializer: tests queue expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_lane_snapshot_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] a = '0, b = '0, c = '0, d = '0;
    logic [7:0] out_data;
    logic [1:0] out_lane;
    logic       out_last, out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] fifo_level;
    logic [7:0] drop_cnt;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] lane;
        logic       last;
    } beat_t;
    beat_t sb[$];

    lane_snapshot_serializer #(.DATA_W(8), .DEPTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .out_data   (out_data),
        .out_lane   (out_lane),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            beat_t got, exp;
            got = '{data: out_data, lane: out_lane, last: out_last};
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL beat_unexpected: got data=%0d lane=%0d last=%0d, expected no beat",
                         out_data, out_lane, out_last);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    fails++;
                    $display("FAIL beat: got data=%0d lane=%0d last=%0d, expected data=%0d lane=%0d last=%0d",
                             got.data, got.lane, got.last, exp.data, exp.lane, exp.last);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [7:0] va, vb, vc, vd);
        a = va; b = vb; c = vc; d = vd;
    endtask

    task automatic push_snap(input logic [7:0] va, vb, vc, vd);
        sb.push_back('{data: va, lane: 2'd0, last: 1'b0});
        sb.push_back('{data: vb, lane: 2'd1, last: 1'b0});
        sb.push_back('{data: vc, lane: 2'd2, last: 1'b0});
        sb.push_back('{data: vd, lane: 2'd3, last: 1'b1});
    endtask

    task automatic wait_drain(input int bound, input string name);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d beats still pending after %0d cycles, expected 0", name, sb.size(), bound);
            sb.delete();
        end
        tick();
        tick();
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; out_ready = 1'b1;
        #1;
        tests++;
        if ({out_valid, out_data, out_lane, out_last, fifo_level, drop_cnt, overflow} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%0d data=%0d lane=%0d last=%0d level=%0d drop=%0d ovf=%0d, expected all 0",
                     out_valid, out_data, out_lane, out_last, fifo_level, drop_cnt, overflow);
        end
        tick();
    endtask

    task automatic test_first_snapshot();
        rst = 1'b1;
        tick();
        en = 1'b1;
        set_lanes(8'd8, 8'd7, 8'd6, 8'd5);
        push_snap(8'd8, 8'd7, 8'd6, 8'd5);
        tick();
        check_val("first_latency_valid", int'(out_valid), 1);
        check_val("first_latency_data", int'(out_data), 8);
        wait_drain(20, "first");
        repeat (4) tick();
        check_val("first_idle_valid", int'(out_valid), 0);
        check_val("first_level", int'(fifo_level), 0);
    endtask

    task automatic test_hold();
        set_lanes(8'd9, 8'd8, 8'd7, 8'd6);
        push_snap(8'd9, 8'd8, 8'd7, 8'd6);
        repeat (10) tick();
        wait_drain(20, "hold");
        check_val("hold_level", int'(fifo_level), 0);
        check_val("hold_valid", int'(out_valid), 0);
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            logic [7:0] base;
            base = 8'(8'h20 + 8'(k * 4));
            set_lanes(base, base + 8'd1, base + 8'd2, base + 8'd3);
            if (k < 4) push_snap(base, base + 8'd1, base + 8'd2, base + 8'd3);
            tick();
        end
        tick();
        check_val("ovf_level", int'(fifo_level), 4);
        check_val("ovf_drop_cnt", int'(drop_cnt), 2);
        check_val("ovf_flag", int'(overflow), 1);
        out_ready = 1'b1;
        wait_drain(40, "ovf");
        check_val("ovf_level_after", int'(fifo_level), 0);
    endtask

    task automatic test_toggle_ready();
        logic       stalled = 1'b0;
        logic [7:0] held = '0;
        set_lanes(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        push_snap(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (stalled) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    fails++;
                    $display("FAIL toggle_stall_hold: got valid=%0d data=%0d, expected valid=1 data=%0d",
                             out_valid, out_data, held);
                end
            end
            out_ready = ~out_ready;
            stalled   = out_valid && !out_ready;
            held      = out_data;
        end
        out_ready = 1'b1;
        wait_drain(20, "toggle");
    endtask

    task automatic test_reset_mid_burst();
        set_lanes(8'h31, 8'h32, 8'h33, 8'h34);
        sb.push_back('{data: 8'h31, lane: 2'd0, last: 1'b0});
        sb.push_back('{data: 8'h32, lane: 2'd1, last: 1'b0});
        tick();
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        check_val("midrst_valid", int'(out_valid), 0);
        check_val("midrst_level", int'(fifo_level), 0);
        check_val("midrst_drop_cnt", int'(drop_cnt), 0);
        check_val("midrst_pending", sb.size(), 0);
        #2;
        rst = 1'b1;
        out_ready = 1'b1;
        push_snap(8'h31, 8'h32, 8'h33, 8'h34);
        wait_drain(20, "midrst");
    endtask

    task automatic test_enable_and_saturation();
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_lanes(8'(k), 8'h77, 8'h66, 8'(k + 1));
            tick();
        end
        set_lanes(8'h31, 8'h32, 8'h33, 8'h34);
        tick();
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL en_no_snapshot: got valid=%0d, expected 0", out_valid);
            end
        end
        out_ready = 1'b0;
        for (int k = 0; k < 264; k++) begin
            logic [15:0] kk;
            kk = 16'(k);
            set_lanes(kk[7:0], kk[15:8], 8'hEE, 8'h11);
            if (k < 4) push_snap(kk[7:0], kk[15:8], 8'hEE, 8'h11);
            tick();
            if (k == 103) check_val("sat_drop_mid", int'(drop_cnt), 100);
        end
        tick();
        check_val("sat_drop_cnt", int'(drop_cnt), 255);
        check_val("sat_overflow", int'(overflow), 1);
        out_ready = 1'b1;
        wait_drain(40, "sat");
        check_val("sat_drop_hold", int'(drop_cnt), 255);
    endtask

    initial begin
        test_reset();
        test_first_snapshot();
        test_hold();
        test_overflow();
        test_toggle_ready();
        test_reset_mid_burst();
        test_enable_and_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
